// File: rtl/serv_dbg_ctrl.sv
// Debug-module halt/resume controller for the SERV core: decodes DMI accesses to
// dmcontrol/dmstatus and sequences halt, resume, single-step and ndmreset toward the hart.
module serv_dbg_ctrl #(
    parameter int HALT_TIMEOUT = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_dmi_req,
    input  logic        i_dmi_we,
    input  logic [6:0]  i_dmi_addr,
    input  logic [31:0] i_dmi_wdata,
    output logic        o_dmi_ack,
    output logic [31:0] o_dmi_rdata,
    output logic        o_dbg_halt,
    output logic        o_dbg_resume,
    output logic        o_dbg_reset,
    input  logic        i_halted,
    input  logic        i_dbg_step
);
    localparam int CNT_W = (HALT_TIMEOUT < 1) ? 1 : $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS  = 7'h11;

    typedef enum logic [2:0] {
        RUNNING    = 3'd0,
        HALT_REQ   = 3'd1,
        HALTED     = 3'd2,
        RESUME_REQ = 3'd3,
        STEPPING   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ack;
    logic             gap;
    logic             sample;
    logic             wr_ctrl;
    logic             resume_go;
    logic             enter_halted;
    logic             haltreq;
    logic             ndmreset;
    logic             dmactive;
    logic             haltreq_next;
    logic             ndmreset_next;
    logic             dmactive_next;
    logic             unavail;
    logic             resumeack;
    logic             havereset;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      status;
    logic [31:0]      rd_val;
    logic             unused_wdata;

    assign unused_wdata = ^{i_dmi_wdata[29], i_dmi_wdata[27:2]};

    // The gap register enforces one idle cycle after every ack before a new sample.
    assign sample    = i_dmi_req && !ack && !gap;
    assign wr_ctrl   = sample && i_dmi_we && (i_dmi_addr == ADDR_DMCONTROL);
    assign resume_go = wr_ctrl && i_dmi_wdata[0] && i_dmi_wdata[30] && !i_dmi_wdata[31]
                       && (state == HALTED);
    assign enter_halted = (state_next == HALTED) && (state != HALTED);

    always_comb begin
        haltreq_next  = haltreq;
        ndmreset_next = ndmreset;
        dmactive_next = dmactive;
        if (wr_ctrl) begin
            dmactive_next = i_dmi_wdata[0];
            haltreq_next  = i_dmi_wdata[0] && i_dmi_wdata[31];
            ndmreset_next = i_dmi_wdata[0] && i_dmi_wdata[1];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUNNING: begin
                if (i_halted)     state_next = HALTED;
                else if (haltreq) state_next = HALT_REQ;
            end
            HALT_REQ: begin
                if (i_halted) state_next = HALTED;
            end
            HALTED: begin
                if (resume_go) state_next = RESUME_REQ;
            end
            RESUME_REQ: begin
                if (!i_halted) state_next = i_dbg_step ? STEPPING : RUNNING;
            end
            STEPPING: begin
                if (i_halted) state_next = HALTED;
            end
            default: state_next = RUNNING;
        endcase
        // An inactive debug module or a system reset in progress pins the hart view to RUNNING.
        if (!dmactive || ndmreset) state_next = RUNNING;
    end

    always_comb begin
        status        = '0;
        status[3:0]   = 4'd3;
        status[7]     = 1'b1;
        status[9:8]   = {2{state == HALTED}};
        status[11:10] = {2{(state == RUNNING) || (state == STEPPING)}};
        status[13:12] = {2{unavail}};
        status[17:16] = {2{resumeack}};
        status[19:18] = {2{havereset}};
    end

    always_comb begin
        rd_val = '0;
        case (i_dmi_addr)
            ADDR_DMCONTROL: rd_val = {haltreq, 29'd0, ndmreset, dmactive};
            ADDR_DMSTATUS:  rd_val = status;
            default:        rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack         <= 1'b0;
            gap         <= 1'b0;
            o_dmi_rdata <= '0;
        end else begin
            ack         <= sample;
            gap         <= ack;
            o_dmi_rdata <= (sample && !i_dmi_we) ? rd_val : 32'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= RUNNING;
        else          state <= state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            haltreq   <= 1'b0;
            ndmreset  <= 1'b0;
            dmactive  <= 1'b0;
            unavail   <= 1'b0;
            resumeack <= 1'b0;
            havereset <= 1'b0;
            cnt       <= '0;
        end else begin
            haltreq  <= haltreq_next;
            ndmreset <= ndmreset_next;
            dmactive <= dmactive_next;
            if (!dmactive) begin
                unavail   <= 1'b0;
                resumeack <= 1'b0;
                havereset <= 1'b0;
                cnt       <= '0;
            end else begin
                if (ndmreset || (state != HALT_REQ)) cnt <= '0;
                else if (cnt != CNT_MAX)             cnt <= cnt + CNT_W'(1);

                // cnt holds N-1 during the N-th cycle spent in HALT_REQ.
                if (ndmreset || enter_halted)                    unavail <= 1'b0;
                else if ((state == HALT_REQ) && (cnt >= CNT_LAST)) unavail <= 1'b1;

                if (resume_go)                                 resumeack <= 1'b0;
                else if ((state == RESUME_REQ) && !i_halted)   resumeack <= 1'b1;

                if (ndmreset && !ndmreset_next)        havereset <= 1'b1;
                else if (wr_ctrl && i_dmi_wdata[28])   havereset <= 1'b0;
            end
        end
    end

    assign o_dmi_ack    = ack;
    assign o_dbg_halt   = (state == HALT_REQ) || ((state == HALTED) && haltreq);
    assign o_dbg_resume = (state == RESUME_REQ);
    assign o_dbg_reset  = ndmreset;

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// Self-checking bench for serv_dbg_ctrl: a DMI vector table from reset, then directed
// halt / resume / single-step / timeout / async-reset sequences.
module tb_serv_dbg_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_dmi_req;
    logic        i_dmi_we;
    logic [6:0]  i_dmi_addr;
    logic [31:0] i_dmi_wdata;
    logic        o_dmi_ack;
    logic [31:0] o_dmi_rdata;
    logic        o_dbg_halt;
    logic        o_dbg_resume;
    logic        o_dbg_reset;
    logic        i_halted;
    logic        i_dbg_step;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_reset;
        logic        exp_resume;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    serv_dbg_ctrl #(.HALT_TIMEOUT(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_dmi_req    (i_dmi_req),
        .i_dmi_we     (i_dmi_we),
        .i_dmi_addr   (i_dmi_addr),
        .i_dmi_wdata  (i_dmi_wdata),
        .o_dmi_ack    (o_dmi_ack),
        .o_dmi_rdata  (o_dmi_rdata),
        .o_dbg_halt   (o_dbg_halt),
        .o_dbg_resume (o_dbg_resume),
        .o_dbg_reset  (o_dbg_reset),
        .i_halted     (i_halted),
        .i_dbg_step   (i_dbg_step)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic dmi(input logic we, input logic [6:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
        bit got;
        got         = 1'b0;
        i_dmi_req   = 1'b1;
        i_dmi_we    = we;
        i_dmi_addr  = addr;
        i_dmi_wdata = wd;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge i_clk);
            #1;
            got = o_dmi_ack;
        end
        check("dmi_ack", {31'd0, got}, 32'd1);
        rd        = o_dmi_rdata;
        i_dmi_req = 1'b0;
        i_dmi_we  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] wd);
        logic [31:0] unused_rd;
        dmi(1'b1, 7'h10, wd, unused_rd);
    endtask

    task automatic rd_check(input string name, input logic [6:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        dmi(1'b0, addr, 32'd0, rd);
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b0, 7'h11, 32'h0000_0000, 32'h0000_0C83, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 7'h10, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 7'h10, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 7'h10, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 7'h20, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 7'h20, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 7'h10, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 7'h10, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 7'h10, 32'h0000_0000, 32'h0000_0003, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 7'h11, 32'h0000_0000, 32'h0000_0C83, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 7'h10, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 7'h11, 32'h0000_0000, 32'h000C_0C83, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 7'h10, 32'h1000_0001, 32'h0000_0000, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 7'h11, 32'h0000_0000, 32'h0000_0C83, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 7'h10, 32'h4000_0001, 32'h0000_0000, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 7'h11, 32'h0000_0000, 32'h0000_0C83, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 7'h10, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 7'h10, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 7'h10, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};

        i_rst_n     = 1'b0;
        i_dmi_req   = 1'b0;
        i_dmi_we    = 1'b0;
        i_dmi_addr  = '0;
        i_dmi_wdata = '0;
        i_halted    = 1'b0;
        i_dbg_step  = 1'b0;
        tick(3);
        check("reset_ack",    {31'd0, o_dmi_ack},    32'd0);
        check("reset_rdata",  o_dmi_rdata,           32'd0);
        check("reset_halt",   {31'd0, o_dbg_halt},   32'd0);
        check("reset_resume", {31'd0, o_dbg_resume}, 32'd0);
        check("reset_reset",  {31'd0, o_dbg_reset},  32'd0);
        i_rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < NVEC; i++) begin
            dmi(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d_reset", i),  {31'd0, o_dbg_reset},  {31'd0, vecs[i].exp_reset});
            check($sformatf("vec%0d_resume", i), {31'd0, o_dbg_resume}, {31'd0, vecs[i].exp_resume});
            tick(2);
        end

        // Basic halt: halt request rises one cycle after the ack.
        wr(32'h8000_0001);
        check("halt_at_ack", {31'd0, o_dbg_halt}, 32'd0);
        tick(1);
        check("halt_after_ack", {31'd0, o_dbg_halt}, 32'd1);
        tick(4);
        i_halted = 1'b1;
        tick(2);
        rd_check("halt_status", 7'h11, 32'h0000_0383);
        rd_check("halt_dmcontrol", 7'h10, 32'h8000_0001);
        check("halt_level_halted", {31'd0, o_dbg_halt}, 32'd1);

        // resumereq together with haltreq is ignored.
        tick(2);
        wr(32'hC000_0001);
        check("both_resume_ack", {31'd0, o_dbg_resume}, 32'd0);
        tick(2);
        check("both_resume_later", {31'd0, o_dbg_resume}, 32'd0);
        rd_check("both_status", 7'h11, 32'h0000_0383);

        // Resume: level held until the core leaves debug mode.
        tick(2);
        wr(32'h4000_0001);
        check("resume_c0", {31'd0, o_dbg_resume}, 32'd1);
        check("resume_halt_low", {31'd0, o_dbg_halt}, 32'd0);
        tick(1);
        check("resume_c1", {31'd0, o_dbg_resume}, 32'd1);
        tick(1);
        check("resume_c2", {31'd0, o_dbg_resume}, 32'd1);
        tick(1);
        i_halted = 1'b0;
        check("resume_c3", {31'd0, o_dbg_resume}, 32'd1);
        tick(1);
        check("resume_done", {31'd0, o_dbg_resume}, 32'd0);
        tick(1);
        rd_check("resume_status", 7'h11, 32'h0003_0C83);

        // Single step.
        tick(2);
        wr(32'h8000_0001);
        tick(2);
        i_halted = 1'b1;
        tick(2);
        rd_check("step_pre_status", 7'h11, 32'h0003_0383);
        tick(2);
        i_dbg_step = 1'b1;
        wr(32'h4000_0001);
        tick(2);
        i_halted = 1'b0;
        tick(1);
        check("step_resume_low", {31'd0, o_dbg_resume}, 32'd0);
        rd_check("step_running_status", 7'h11, 32'h0003_0C83);
        tick(6);
        i_halted = 1'b1;
        tick(2);
        rd_check("step_halted_status", 7'h11, 32'h0003_0383);
        check("step_halt_level", {31'd0, o_dbg_halt}, 32'd0);
        i_dbg_step = 1'b0;
        tick(2);
        wr(32'h4000_0001);
        tick(1);
        i_halted = 1'b0;
        tick(2);

        // Halt timeout with HALT_TIMEOUT=8.
        wr(32'h8000_0001);
        rd_check("timeout_early_status", 7'h11, 32'h0003_0083);
        tick(12);
        rd_check("timeout_status", 7'h11, 32'h0003_3083);
        check("timeout_halt_level", {31'd0, o_dbg_halt}, 32'd1);
        i_halted = 1'b1;
        tick(2);
        rd_check("timeout_cleared_status", 7'h11, 32'h0003_0383);
        tick(2);
        wr(32'h4000_0001);
        tick(1);
        i_halted = 1'b0;
        tick(2);

        // Asynchronous reset in HALT_REQ with a read in flight.
        wr(32'h8000_0001);
        tick(2);
        check("rst_pre_halt", {31'd0, o_dbg_halt}, 32'd1);
        i_dmi_req  = 1'b1;
        i_dmi_we   = 1'b0;
        i_dmi_addr = 7'h11;
        tick(1);
        check("rst_pre_ack", {31'd0, o_dmi_ack}, 32'd1);
        check("rst_pre_rdata", o_dmi_rdata, 32'h0003_0083);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_ack",    {31'd0, o_dmi_ack},    32'd0);
        check("rst_rdata",  o_dmi_rdata,           32'd0);
        check("rst_halt",   {31'd0, o_dbg_halt},   32'd0);
        check("rst_resume", {31'd0, o_dbg_resume}, 32'd0);
        check("rst_reset",  {31'd0, o_dbg_reset},  32'd0);
        i_dmi_req = 1'b0;
        tick(2);
        i_rst_n = 1'b1;
        tick(2);
        rd_check("post_rst_dmcontrol", 7'h10, 32'h0000_0000);
        rd_check("post_rst_status", 7'h11, 32'h0000_0C83);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serv_dbg_ctrl.md
# serv_dbg_ctrl

Debug-module halt/resume controller that drives the SERV core's debug-halt interface from the debugger side. It decodes DMI register accesses to `dmcontrol` (0x10) and `dmstatus` (0x11) and sequences halt, resume, single-step and `ndmreset` requests toward the core. It tracks the hart's run state from core status and reports it back over DMI. It sits between the debug transport (DTM/DMI) and the core's `i_dbg_halt`/`i_dbg_reset`/`dcsr.step` signals.

## Interface
- `HALT_TIMEOUT`, default 1023: cycles allowed in HALT_REQ before the hart is flagged unavailable. Minimum 1.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_dmi_req`  in  1  DMI request valid; held high until `o_dmi_ack`.
- `i_dmi_we`  in  1  1 = write, 0 = read.
- `i_dmi_addr`  in  7  DMI register address.
- `i_dmi_wdata`  in  32  write data.
- `o_dmi_ack`  out  1  one-cycle completion pulse.
- `o_dmi_rdata`  out  32  read data, valid while `o_dmi_ack` is high.
- `o_dbg_halt`  out  1  halt request level to core.
- `o_dbg_resume`  out  1  resume request level to core.
- `o_dbg_reset`  out  1  `ndmreset` level to core/system.
- `i_halted`  in  1  core is in debug mode (halt request or ebreak taken).
- `i_dbg_step`  in  1  core `dcsr.step` value.

## Operation
- `dmcontrol` write fields: bit31 `haltreq`, bit30 `resumereq`, bit28 `ackhavereset`, bit1 `ndmreset`, bit0 `dmactive`. A read returns `haltreq`, `ndmreset` and `dmactive` as stored; all other bits read 0.
- `dmstatus` is read-only:
  - [3:0] = 3 (spec 1.0).
  - bit7 `authenticated` = 1.
  - bits 9/8 all/anyhalted = (state==HALTED).
  - bits 11/10 all/anyrunning = (state==RUNNING or STEPPING).
  - bits 13/12 all/anyunavail = `unavail` sticky.
  - bits 17/16 all/anyresumeack = `resumeack` sticky.
  - bits 19/18 all/anyhavereset = `havereset` sticky.
  - All other bits read 0.
- Other addresses: reads return 0; writes are ignored.
- `dmactive`=0 holds the block in its reset state: FSM in RUNNING, stickies cleared, `haltreq`/`ndmreset` cleared. The `dmactive` write itself is still accepted.
- FSM states: RUNNING, HALT_REQ, HALTED, RESUME_REQ, STEPPING.
  - **RUNNING:**
    - `i_halted`=1 → HALTED (ebreak entry).
    - Otherwise, stored `haltreq`=1 → HALT_REQ.
  - **HALT_REQ:**
    - `o_dbg_halt`=1 and the timeout counter increments each cycle.
    - `i_halted` → HALTED.
    - Counter reaches `HALT_TIMEOUT` → set `unavail`, stay in HALT_REQ.
  - **HALTED:**
    - `o_dbg_halt` = stored `haltreq`.
    - Write with `resumereq`=1 and `haltreq`=0 → clear `resumeack`, go to RESUME_REQ.
    - `resumereq` together with `haltreq`=1 is ignored.
  - **RESUME_REQ:**
    - `o_dbg_resume`=1.
    - `i_halted` falls → set `resumeack`; go to STEPPING if `i_dbg_step`=1, else RUNNING.
  - **STEPPING:** `i_halted` rises → HALTED. A `haltreq` write here is recorded but takes effect only through the core's step halt.
- `resumereq` outside HALTED is ignored (single-cycle action, never stored).
- `ndmreset`: `o_dbg_reset` follows the stored bit. While it is 1:
  - FSM is forced to RUNNING and the timeout counter and `unavail` are cleared.
  - `havereset` is set on the falling edge of the stored bit.
  - Writing `ackhavereset`=1 clears `havereset`.
- `unavail` is cleared on entry to HALTED.

## Timing
- Reset values: `o_dmi_ack`=0, `o_dmi_rdata`=0, `o_dbg_halt`=0, `o_dbg_resume`=0, `o_dbg_reset`=0, state RUNNING, all stickies 0, counter 0.
- DMI handshake:
  - Request is sampled on the first cycle `i_dmi_req`=1 with no access in progress.
  - `o_dmi_ack` pulses exactly one cycle later.
  - Write effects are visible in registers on the ack cycle.
  - The read value reflects state at the sample edge.
  - After an ack, at least one cycle must pass before a new request is sampled.
- Halt latency: `o_dbg_halt` rises on the cycle after the `haltreq` write ack, i.e. state HALT_REQ is registered one cycle after ack.
- HALTED is registered one cycle after `i_halted` is seen.
- `o_dbg_resume` deasserts in the same cycle the state leaves RESUME_REQ.
- Timeout: `unavail` is set on the `HALT_TIMEOUT`-th cycle in HALT_REQ. The counter saturates.
- `i_rst_n` low mid-operation: all outputs return to reset values immediately (async), including during an outstanding DMI access; that request must be re-issued.

## Test plan
- **Basic halt:** write `dmcontrol`=0x8000_0001; assert `i_halted` 5 cycles later → `o_dbg_halt`=1 one cycle after ack; `dmstatus` read = 0x0000_0383.
- **Resume:** from HALTED, write 0x4000_0001; drop `i_halted` 3 cycles later → `o_dbg_resume` high for those cycles then 0; `dmstatus`=0x0003_0C83.
- **Single step:** same resume with `i_dbg_step`=1; raise `i_halted` 10 cycles after it fell → STEPPING then HALTED; `dmstatus` bits 9:8 = 2'b11 and `resumeack`=1.
- **Timeout:** `HALT_TIMEOUT`=8, write `haltreq`, never assert `i_halted` → bits 13:12 = 2'b11 after 8 cycles; assert `i_halted` → bits clear, HALTED.
- **ndmreset:** write 0x0000_0003 then 0x0000_0001 → `o_dbg_reset` high between the two acks; `havereset` bits 19:18 set; write 0x1000_0001 → cleared.
- **Edge cases:**
  - Write 0xC000_0001 while HALTED → resume ignored, `o_dbg_resume` stays 0.
  - Read address 0x20 → rdata 0.
  - Pulse `i_rst_n` low mid-HALT_REQ → all outputs 0.
